prach_hb2_sched: RTL
====================

Name: prach_hb2_sched

Overview:
Input-side scheduler for the two-channel (I/Q) halfband-2 decimator stage of the PRACH long-sequence chain.
- Accepts a TDM stream of I/Q samples, one sample per valid cycle, tagged with a carrier/antenna channel index.
- Pairs consecutive samples of the same channel into phase-1/phase-2 operands.
- Issues each pair with its channel index and a frame sync pulse, in the format the decimator consumes.
- Checks TDM order and flags protocol errors through sticky status bits.

Parameters:
NUM_CH, 8, number of TDM channels per frame (1..256).
CHN_W, 8, channel index width; must satisfy 2**CHN_W >= NUM_CH.

Ports:
clk  in  1  single clock for the block.
rst_n  in  1  asynchronous active-low reset.
en  in  1  scheduler enable; low discards input and clears pairing state.
din_dq  in  16x2  input sample; [0]=I, [1]=Q, signed.
din_chn  in  CHN_W  channel index of din_dq.
din_valid  in  1  din_dq/din_chn valid this cycle.
sync_in  in  1  frame start; qualifies the same-cycle input as the first sample of the frame.
dout_dp1  out  16x2  earlier (even) sample of the pair.
dout_dp2  out  16x2  later (odd) sample of the pair.
dout_chn  out  CHN_W  channel of the pair.
dout_valid  out  1  pair valid.
sync_out  out  1  marks the first pair issued after a sync_in.
err_chn  out  1  sticky: din_chn >= NUM_CH seen.
err_order  out  1  sticky: din_chn differs from the expected TDM slot.
err_clr  in  1  clears both sticky errors; a same-cycle new error still sets the bit.

Behaviour:
- Reset values: all outputs 0; phase bits 0 (even); expected-channel counter 0; sync-pending flag 0; holding memory contents don't-care.
- State per channel:
  - Phase bit: even or odd.
  - Holding register (32 bits), written on even phase.
- Expected-channel counter exp_chn:
  - Increments on each accepted sample.
  - Wraps NUM_CH-1 -> 0.
  - sync_in forces the sample under test to compare against 0; the counter then loads 1 (or 0 when NUM_CH=1).
- Sample acceptance condition: en && din_valid && din_chn < NUM_CH.
- din_chn >= NUM_CH:
  - Sample dropped; err_chn set.
  - exp_chn still increments; no state change otherwise.
- Order check: an accepted sample with din_chn != exp_chn sets err_order. The sample is still processed on its own channel; there is no resync except via sync_in.
- Even phase: store din_dq in holding[din_chn]; toggle phase; no output.
- Odd phase, registered on the next cycle:
  - dout_dp1 = holding[din_chn], dout_dp2 = din_dq, dout_chn = din_chn, dout_valid = 1; toggle phase.
  - Latency is 1 clock from the odd input to the output.
- Output hold: when dout_valid=0, dout_dp1/dout_dp2/dout_chn hold their last values and sync_out=0.
- Sync handling:
  - sync_in (with en && din_valid) clears all phase bits in the same cycle, so the qualifying sample is treated as even, and sets sync-pending.
  - sync_out is asserted with the next dout_valid pulse and clears sync-pending.
  - sync_in arriving while sync-pending is already set leaves one pending sync (no queueing).
- Throughput: at most one pair per cycle; no backpressure. The stream must tolerate a 50% output duty.
- en deasserted:
  - Same cycle: inputs ignored, all phase bits cleared, sync-pending cleared, exp_chn reset to 0.
  - A pair already registered in the output stage is still presented for its single cycle.
- Simultaneous err_clr with a new error: the error bit remains set.
- Reset mid-operation: asynchronous return to reset values. Partially paired samples are lost; no pair is emitted after rst_n deasserts until a fresh even/odd pair arrives.
- Arithmetic: none; samples pass through bit-exact.

Decomposition:
- Shared package prach_pkg:
  - Default NUM_CH constant.
  - iq_t (16-bit signed I/Q pair typedef).
  - chn_t sized by CHN_W.
- One natural sub-module, prach_hb2_sched_hold: the NUM_CH x 32 holding memory with one write port and one read port, registered read-before-write for the same address. It may map to distributed RAM.
- Phase bits stay as a flop vector in the top so the bulk clear is single-cycle.

Test Plan:
1. NUM_CH=4; sync_in with chn0; feed chn0,1,2,3,0,1,2,3 with samples equal to 10*chn+k -> four pairs, chn0..3.
   - chn0 pair is dp1=(0,0), dp2=(1,1).
   - sync_out only on the chn0 pair; latency 1 cycle after each odd input; errors 0.
2. Gapped din_valid (valid every 3rd cycle) over two frames -> identical pairs with the same values as scenario 1; dout_valid is a single-cycle pulse each time.
3. Inject din_chn=5 with NUM_CH=4 mid-frame -> err_chn=1, no pair for it.
   - Next sample expected at the following slot; a mismatch sets err_order.
   - err_clr -> both errors 0.
4. sync_in mid-frame after an even chn2 sample -> chn2 phase reset.
   - The following chn2 sample is stored as even, with no pair emitted.
   - sync_out accompanies the first pair after the sync.
5. Deassert en for 5 cycles between even and odd samples of chn1 -> no pair for chn1.
   - After en returns with sync_in, normal pairing resumes from even.
6. Assert rst_n low while an odd sample is in flight -> all outputs 0 immediately; no stale pair after release.

Source files
------------

// File: rtl/prach_pkg.sv
// Shared types and defaults for the PRACH long-sequence chain.
// - NUM_CH_DEF / CHN_W_DEF : default TDM channel count and channel index width
// - iq_t  : one signed I/Q sample pair, [0]=I, [1]=Q
// - chn_t : channel index at the default width
package prach_pkg;
    localparam int NUM_CH_DEF = 8;
    localparam int CHN_W_DEF  = 8;

    typedef logic signed [1:0][15:0] iq_t;
    typedef logic [CHN_W_DEF-1:0]    chn_t;
endpackage

// File: rtl/prach_hb2_sched_hold.sv
// Per-channel holding memory for the even-phase sample of each I/Q pair.
// - wr_en/wr_addr/wr_data : write port, used on the even phase
// - rd_en/rd_addr         : read port, used on the odd phase
// - rd_data               : registered read data; holds its value between reads
//   and returns the contents from before any same-edge write.
// The array itself has no reset so it can map to distributed RAM.
module prach_hb2_sched_hold
    import prach_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  iq_t           wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output iq_t           rd_data
);

    localparam int DEPTH = 2 ** AW;

    iq_t mem_r [DEPTH];

    // Write port: store the even-phase sample of a channel
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register: doubles as the dp1 output stage, so it only moves on a read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/prach_hb2_sched.sv
// Input-side scheduler for the two-channel halfband-2 decimator.
// Pairs consecutive samples of each TDM channel into (dp1, dp2) operands,
// checks TDM slot order and reports protocol errors as sticky bits.
// - clk, rst_n            : clock, asynchronous active-low reset
// - en                    : low discards input and clears pairing state
// - din_dq/din_chn/din_valid/sync_in : TDM sample stream, sync marks slot 0
// - dout_dp1/dout_dp2/dout_chn/dout_valid/sync_out : pair output, 1-cycle latency
// - err_chn/err_order/err_clr : sticky error bits and their clear
module prach_hb2_sched
    import prach_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CHN_W  = CHN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  iq_t              din_dq,
    input  logic [CHN_W-1:0] din_chn,
    input  logic             din_valid,
    input  logic             sync_in,
    output iq_t              dout_dp1,
    output iq_t              dout_dp2,
    output logic [CHN_W-1:0] dout_chn,
    output logic             dout_valid,
    output logic             sync_out,
    output logic             err_chn,
    output logic             err_order,
    input  logic             err_clr
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PH_N  = 2 ** IDX_W;
    localparam logic [CHN_W-1:0] EXP_AFTER_SYNC = (NUM_CH == 1) ? {CHN_W{1'b0}} : CHN_W'(1);

    logic [PH_N-1:0]  phase_r;
    logic [PH_N-1:0]  phase_nxt_s;
    logic [CHN_W-1:0] exp_chn_r;
    logic [CHN_W-1:0] exp_chn_nxt_s;
    logic             sync_pend_r;
    logic             sync_pend_nxt_s;

    logic             in_qual_s;
    logic             chn_ok_s;
    logic             accept_s;
    logic             sync_q_s;
    logic [IDX_W-1:0] idx_s;
    logic [CHN_W-1:0] exp_cmp_s;
    logic             phase_cur_s;
    logic             even_s;
    logic             odd_s;
    logic             order_bad_s;
    logic             chn_bad_s;

    assign in_qual_s = en & din_valid;
    assign chn_ok_s  = (32'(din_chn) < NUM_CH);
    assign accept_s  = in_qual_s & chn_ok_s;
    assign chn_bad_s = in_qual_s & ~chn_ok_s;
    assign sync_q_s  = in_qual_s & sync_in;
    // Only the low bits address per-channel state; accept_s guarantees range.
    assign idx_s     = din_chn[IDX_W-1:0];

    // Sync forces the qualifying sample to slot 0 and to the even phase
    always_comb begin
        exp_cmp_s   = exp_chn_r;
        phase_cur_s = phase_r[idx_s];
        if (sync_q_s) begin
            exp_cmp_s   = {CHN_W{1'b0}};
            phase_cur_s = 1'b0;
        end else begin
            exp_cmp_s   = exp_chn_r;
            phase_cur_s = phase_r[idx_s];
        end
    end

    assign even_s      = accept_s & ~phase_cur_s;
    assign odd_s       = accept_s & phase_cur_s;
    assign order_bad_s = accept_s & (din_chn != exp_cmp_s);

    // Next-state for phase bits, expected slot counter and sync-pending flag
    always_comb begin
        phase_nxt_s     = phase_r;
        exp_chn_nxt_s   = exp_chn_r;
        sync_pend_nxt_s = sync_pend_r;
        if (!en) begin
            phase_nxt_s     = {PH_N{1'b0}};
            exp_chn_nxt_s   = {CHN_W{1'b0}};
            sync_pend_nxt_s = 1'b0;
        end else if (din_valid) begin
            if (sync_q_s) begin
                phase_nxt_s     = {PH_N{1'b0}};
                exp_chn_nxt_s   = EXP_AFTER_SYNC;
                sync_pend_nxt_s = 1'b1;
            end else begin
                if (32'(exp_chn_r) == NUM_CH - 1) begin
                    exp_chn_nxt_s = {CHN_W{1'b0}};
                end else begin
                    exp_chn_nxt_s = exp_chn_r + CHN_W'(1);
                end
                if (odd_s) begin
                    sync_pend_nxt_s = 1'b0;
                end else begin
                    sync_pend_nxt_s = sync_pend_r;
                end
            end
            if (accept_s) begin
                phase_nxt_s[idx_s] = ~phase_cur_s;
            end else begin
                phase_nxt_s[idx_s] = phase_nxt_s[idx_s];
            end
        end else begin
            phase_nxt_s     = phase_r;
            exp_chn_nxt_s   = exp_chn_r;
            sync_pend_nxt_s = sync_pend_r;
        end
    end

    // Pairing and slot-tracking state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r     <= {PH_N{1'b0}};
            exp_chn_r   <= {CHN_W{1'b0}};
            sync_pend_r <= 1'b0;
        end else begin
            phase_r     <= phase_nxt_s;
            exp_chn_r   <= exp_chn_nxt_s;
            sync_pend_r <= sync_pend_nxt_s;
        end
    end

    prach_hb2_sched_hold #(
        .AW (IDX_W)
    ) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (even_s),
        .wr_addr (idx_s),
        .wr_data (din_dq),
        .rd_en   (odd_s),
        .rd_addr (idx_s),
        .rd_data (dout_dp1)
    );

    // Output stage: dp2/chn hold between pairs, valid and sync_out are pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_dp2   <= '0;
            dout_chn   <= {CHN_W{1'b0}};
            dout_valid <= 1'b0;
            sync_out   <= 1'b0;
        end else begin
            dout_valid <= odd_s;
            sync_out   <= odd_s & sync_pend_r;
            if (odd_s) begin
                dout_dp2 <= din_dq;
                dout_chn <= din_chn;
            end
        end
    end

    // Sticky errors: a new error in the clear cycle wins over err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_chn   <= 1'b0;
            err_order <= 1'b0;
        end else begin
            err_chn   <= chn_bad_s | (err_chn & ~err_clr);
            err_order <= order_bad_s | (err_order & ~err_clr);
        end
    end

endmodule
